move_selector: RTL and testbench

MOVE_SELECTOR -- requirements
Module: move_selector

---
 rtl/gobang_pkg.sv | 23 ++
 rtl/lfsr16.sv | 25 ++
 rtl/move_selector.sv | 192 +++++++++++++++++++
 tb/tb_move_selector.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/gobang_pkg.sv
// Shared gobang definitions: board geometry defaults, score width default,
// move-selector state encoding and the tie-break LFSR step function.
package gobang_pkg;

   localparam int BOARD_SIZE_DEF = 15;
   localparam int COORD_W        = 4;
   localparam int SCORE_W_DEF    = 13;

   // Move-selector scan states.
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SCAN  = 2'd1,
      ST_DRAIN = 2'd2
   } sel_state_t;

   // Right-shifting Galois LFSR, polynomial x^16 + x^14 + x^13 + x^11 + 1.
   localparam logic [15:0] LFSR_TAPS = 16'hB400;

   function automatic logic [15:0] lfsr_next(input logic [15:0] s);
      return {1'b0, s[15:1]} ^ (s[0] ? LFSR_TAPS : 16'h0000);
   endfunction

endpackage

// File: rtl/lfsr16.sv
// Free-running 16-bit maximal-length Galois LFSR. Loads SEED on reset and
// steps on every clock; the low state bit is the random tie-break bit.
module lfsr16
   import gobang_pkg::*;
#(
   parameter logic [15:0] SEED = 16'hACE1
) (
   input  logic clk,
   input  logic rst,
   output logic rnd
);

   logic [15:0] state;

   // Step the LFSR every cycle; a zero seed would lock it up, so SEED must be nonzero.
   always_ff @(posedge clk or negedge rst) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples the pre-edge value of every other flop.
      if (!rst) state <= SEED;
      else      state <= lfsr_next(state);
   end

   assign rnd = state[0];

endmodule

// File: rtl/move_selector.sv
// Scans every board cell row-major through a one-cycle score/board lookup,
// combines attack and defence scores and reports the best empty cell.
// A scan takes BOARD_SIZE*BOARD_SIZE address cycles plus one drain cycle.
module move_selector
   import gobang_pkg::*;
#(
   parameter int          BOARD_SIZE = BOARD_SIZE_DEF,
   parameter int          SCORE_W    = SCORE_W_DEF,
   parameter int          ATK_SHIFT  = 1,
   parameter int          DEF_SHIFT  = 0,
   parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 clr,
   input  logic                 start,
   input  logic                 side,
   input  logic                 rand_en,
   output logic [COORD_W-1:0]   get_i,
   output logic [COORD_W-1:0]   get_j,
   input  logic                 occupied,
   input  logic [SCORE_W-1:0]   black_score,
   input  logic [SCORE_W-1:0]   white_score,
   output logic                 busy,
   output logic                 done,
   output logic [COORD_W-1:0]   best_i,
   output logic [COORD_W-1:0]   best_j,
   output logic [SCORE_W+3:0]   best_score,
   output logic                 no_move
);

   localparam int                 COMB_W   = SCORE_W + 4;
   localparam logic [COORD_W-1:0] LAST_C   = COORD_W'(BOARD_SIZE - 1);
   localparam logic [COORD_W-1:0] CENTER_C = COORD_W'(BOARD_SIZE / 2);

   sel_state_t          state;
   logic                side_r;
   logic                rand_r;
   logic                rnd;

   // Address pipeline: tags the lookup data returning this cycle.
   logic                pipe_valid;
   logic [COORD_W-1:0]  pipe_i;
   logic [COORD_W-1:0]  pipe_j;

   // Running best of the current scan; published only on done.
   logic                found;
   logic [COORD_W-1:0]  cur_i;
   logic [COORD_W-1:0]  cur_j;
   logic [COMB_W-1:0]   cur_score;

   logic [SCORE_W-1:0]  own;
   logic [SCORE_W-1:0]  opp;
   logic [COMB_W-1:0]   comb;
   logic                take;
   logic                nxt_found;
   logic [COORD_W-1:0]  nxt_i;
   logic [COORD_W-1:0]  nxt_j;
   logic [COMB_W-1:0]   nxt_score;

   lfsr16 #(
      .SEED (LFSR_SEED)
   ) u_lfsr (
      .clk (clk),
      .rst (rst),
      .rnd (rnd)
   );

   // Combine the returned scores and decide whether this cell replaces the running best.
   always_comb begin
      // NOTE: every signal gets a default before any branch so no path
      // leaves it unassigned and no latch is inferred.
      take = 1'b0;
      own  = side_r ? white_score : black_score;
      opp  = side_r ? black_score : white_score;
      // Widening before the shift keeps the full sum; SCORE_W+4 bits cannot overflow.
      comb = (COMB_W'(own) << ATK_SHIFT) + (COMB_W'(opp) << DEF_SHIFT);
      if (pipe_valid && !occupied) begin
         if (!found)                                  take = 1'b1;
         else if (comb > cur_score)                   take = 1'b1;
         else if (comb == cur_score && rand_r && rnd) take = 1'b1;
      end
      nxt_found = found | take;
      nxt_i     = take ? pipe_i : cur_i;
      nxt_j     = take ? pipe_j : cur_j;
      nxt_score = take ? comb   : cur_score;
   end

   // Scan FSM: address generation, lookup pipeline, running best and registered results.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= ST_IDLE;
         side_r     <= 1'b0;
         rand_r     <= 1'b0;
         get_i      <= '0;
         get_j      <= '0;
         pipe_valid <= 1'b0;
         pipe_i     <= '0;
         pipe_j     <= '0;
         found      <= 1'b0;
         cur_i      <= '0;
         cur_j      <= '0;
         cur_score  <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         best_i     <= CENTER_C;
         best_j     <= CENTER_C;
         best_score <= '0;
         no_move    <= 1'b0;
      end else if (clr) begin
         // Abort keeps the last published result; a clear while idle wipes it.
         state      <= ST_IDLE;
         get_i      <= '0;
         get_j      <= '0;
         pipe_valid <= 1'b0;
         found      <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         if (state == ST_IDLE) begin
            best_i     <= CENTER_C;
            best_j     <= CENTER_C;
            best_score <= '0;
            no_move    <= 1'b0;
         end
      end else begin
         case (state)
            ST_IDLE: begin
               done       <= 1'b0;
               pipe_valid <= 1'b0;
               // busy is still high during the done cycle, which blocks a restart there.
               if (start && !busy) begin
                  state     <= ST_SCAN;
                  busy      <= 1'b1;
                  side_r    <= side;
                  rand_r    <= rand_en;
                  get_i     <= '0;
                  get_j     <= '0;
                  found     <= 1'b0;
                  cur_i     <= '0;
                  cur_j     <= '0;
                  cur_score <= '0;
               end else begin
                  busy <= 1'b0;
               end
            end

            ST_SCAN: begin
               pipe_valid <= 1'b1;
               pipe_i     <= get_i;
               pipe_j     <= get_j;
               found      <= nxt_found;
               cur_i      <= nxt_i;
               cur_j      <= nxt_j;
               cur_score  <= nxt_score;
               if (get_j == LAST_C) begin
                  get_j <= '0;
                  if (get_i == LAST_C) begin
                     state <= ST_DRAIN;
                     get_i <= '0;
                  end else begin
                     get_i <= get_i + COORD_W'(1);
                  end
               end else begin
                  get_j <= get_j + COORD_W'(1);
               end
            end

            ST_DRAIN: begin
               // Last cell's data is evaluated here and folded straight into the result.
               state      <= ST_IDLE;
               pipe_valid <= 1'b0;
               found      <= nxt_found;
               cur_i      <= nxt_i;
               cur_j      <= nxt_j;
               cur_score  <= nxt_score;
               done       <= 1'b1;
               no_move    <= !nxt_found;
               best_i     <= nxt_found ? nxt_i : CENTER_C;
               best_j     <= nxt_found ? nxt_j : CENTER_C;
               best_score <= nxt_found ? nxt_score : '0;
            end

            default: begin
               state <= ST_IDLE;
               busy  <= 1'b0;
               done  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_move_selector.sv
// Directed bench for move_selector: a 15x15 instance and a 9x9 instance, each
// fed by a one-cycle-latency board/score lookup model driven from tb arrays.
`timescale 1ns/1ps
module tb_move_selector;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        clr = 1'b0;
   logic        start = 1'b0;
   logic        start9 = 1'b0;
   logic        side = 1'b0;
   logic        rand_en = 1'b0;

   logic [3:0]  get_i, get_j, best_i, best_j;
   logic        occupied, busy, done, no_move;
   logic [12:0] black_score, white_score;
   logic [16:0] best_score;

   logic [3:0]  get_i9, get_j9, best_i9, best_j9;
   logic        occupied9, busy9, done9, no_move9;
   logic [12:0] black_score9, white_score9;
   logic [16:0] best_score9;

   logic        occ_m [0:15][0:15];
   logic [12:0] bs_m  [0:15][0:15];
   logic [12:0] ws_m  [0:15][0:15];

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   move_selector dut (
      .clk(clk), .rst(rst), .clr(clr), .start(start), .side(side), .rand_en(rand_en),
      .get_i(get_i), .get_j(get_j), .occupied(occupied),
      .black_score(black_score), .white_score(white_score),
      .busy(busy), .done(done), .best_i(best_i), .best_j(best_j),
      .best_score(best_score), .no_move(no_move)
   );

   move_selector #(.BOARD_SIZE(9)) dut9 (
      .clk(clk), .rst(rst), .clr(clr), .start(start9), .side(side), .rand_en(rand_en),
      .get_i(get_i9), .get_j(get_j9), .occupied(occupied9),
      .black_score(black_score9), .white_score(white_score9),
      .busy(busy9), .done(done9), .best_i(best_i9), .best_j(best_j9),
      .best_score(best_score9), .no_move(no_move9)
   );

   // Lookup model: data for the address seen at an edge is returned one cycle later.
   always @(posedge clk) begin
      occupied     <= occ_m[get_i][get_j];
      black_score  <= bs_m[get_i][get_j];
      white_score  <= ws_m[get_i][get_j];
      occupied9    <= occ_m[get_i9][get_j9];
      black_score9 <= bs_m[get_i9][get_j9];
      white_score9 <= ws_m[get_i9][get_j9];
   end

   task automatic clear_board(input logic occ_v);
      for (int i = 0; i < 16; i++)
         for (int j = 0; j < 16; j++) begin
            occ_m[i][j] = occ_v;
            bs_m[i][j]  = 13'd0;
            ws_m[i][j]  = 13'd0;
         end
   endtask

   // Issue start to one instance and count cycles to done (bounded).
   task automatic run_scan(input bit use9, output int cyc, output bit seen,
                           output bit busy_first, output int maxc);
      repeat (2) @(negedge clk);
      if (use9) start9 = 1'b1; else start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; start9 = 1'b0;
      busy_first = use9 ? busy9 : busy;
      cyc = 0; seen = 1'b0; maxc = 0;
      for (int c = 1; c <= 400; c++) begin
         @(posedge clk); #1;
         if (use9 && busy9) begin
            if (int'(get_i9) > maxc) maxc = int'(get_i9);
            if (int'(get_j9) > maxc) maxc = int'(get_j9);
         end
         if ((use9 ? done9 : done) === 1'b1) begin
            cyc = c; seen = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset;
      rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
      total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", done); end
      @(negedge clk); rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      total++; if (get_i !== 4'd0 || get_j !== 4'd0) begin bad++; $display("FAIL reset_get got=(%0d,%0d) want=(0,0)", get_i, get_j); end
      total++; if (best_i !== 4'd7 || best_j !== 4'd7) begin bad++; $display("FAIL reset_best got=(%0d,%0d) want=(7,7)", best_i, best_j); end
      total++; if (best_score !== 17'd0) begin bad++; $display("FAIL reset_score got=%0d want=0", best_score); end
      total++; if (no_move !== 1'b0) begin bad++; $display("FAIL reset_no_move got=%b want=0", no_move); end
      total++; if (best_i9 !== 4'd4 || best_j9 !== 4'd4) begin bad++; $display("FAIL reset_best9 got=(%0d,%0d) want=(4,4)", best_i9, best_j9); end
   endtask

   task automatic test_empty_board;
      int cyc; bit seen; bit bf; int mc;
      clear_board(1'b0);
      side = 1'b0; rand_en = 1'b0;
      run_scan(1'b0, cyc, seen, bf, mc);
      total++; if (bf !== 1'b1) begin bad++; $display("FAIL empty_busy_first got=%b want=1", bf); end
      total++; if (!seen || cyc != 226) begin bad++; $display("FAIL empty_latency got=%0d seen=%0d want=226", cyc, seen); end
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL empty_busy_done_cycle got=%b want=1", busy); end
      total++; if (best_i !== 4'd0 || best_j !== 4'd0) begin bad++; $display("FAIL empty_best got=(%0d,%0d) want=(0,0)", best_i, best_j); end
      total++; if (best_score !== 17'd0 || no_move !== 1'b0) begin bad++; $display("FAIL empty_score got=%0d/%b want=0/0", best_score, no_move); end
      @(posedge clk); #1;
      total++; if (done !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL empty_after got done=%b busy=%b want 0/0", done, busy); end
   endtask

   task automatic test_single_peak;
      int cyc; bit seen; bit bf; int mc;
      clear_board(1'b0);
      bs_m[7][9] = 13'd100; ws_m[7][9] = 13'd50;
      side = 1'b0;
      run_scan(1'b0, cyc, seen, bf, mc);
      total++; if (!seen || best_i !== 4'd7 || best_j !== 4'd9) begin bad++; $display("FAIL peak_black_pos got=(%0d,%0d) want=(7,9)", best_i, best_j); end
      total++; if (best_score !== 17'd250) begin bad++; $display("FAIL peak_black_score got=%0d want=250", best_score); end
      side = 1'b1;
      run_scan(1'b0, cyc, seen, bf, mc);
      total++; if (!seen || best_i !== 4'd7 || best_j !== 4'd9) begin bad++; $display("FAIL peak_white_pos got=(%0d,%0d) want=(7,9)", best_i, best_j); end
      total++; if (best_score !== 17'd200) begin bad++; $display("FAIL peak_white_score got=%0d want=200", best_score); end
      side = 1'b0;
   endtask

   task automatic test_all_occupied;
      int cyc; bit seen; bit bf; int mc;
      clear_board(1'b1);
      bs_m[3][3] = 13'd500;
      run_scan(1'b0, cyc, seen, bf, mc);
      total++; if (!seen || no_move !== 1'b1) begin bad++; $display("FAIL full_no_move got=%b want=1", no_move); end
      total++; if (best_i !== 4'd7 || best_j !== 4'd7 || best_score !== 17'd0) begin bad++; $display("FAIL full_best got=(%0d,%0d,%0d) want=(7,7,0)", best_i, best_j, best_score); end
   endtask

   task automatic test_tie_break;
      int cyc; bit seen; bit bf; int mc;
      int hit_a, hit_b, odd;
      clear_board(1'b0);
      bs_m[2][3] = 13'd20; bs_m[11][4] = 13'd20;
      side = 1'b0; rand_en = 1'b0;
      run_scan(1'b0, cyc, seen, bf, mc);
      total++; if (!seen || best_i !== 4'd2 || best_j !== 4'd3 || best_score !== 17'd40) begin bad++; $display("FAIL tie_norand got=(%0d,%0d,%0d) want=(2,3,40)", best_i, best_j, best_score); end
      rand_en = 1'b1;
      hit_a = 0; hit_b = 0; odd = 0;
      for (int k = 0; k < 32; k++) begin
         repeat ($urandom_range(0, 23)) @(posedge clk);
         run_scan(1'b0, cyc, seen, bf, mc);
         if (seen && best_i == 4'd2 && best_j == 4'd3 && best_score == 17'd40) hit_a++;
         else if (seen && best_i == 4'd11 && best_j == 4'd4 && best_score == 17'd40) hit_b++;
         else odd++;
      end
      total++; if (odd != 0) begin bad++; $display("FAIL tie_rand_valid got=%0d bad picks want=0", odd); end
      total++; if (hit_a == 0 || hit_b == 0) begin bad++; $display("FAIL tie_rand_both got a=%0d b=%0d want both>0", hit_a, hit_b); end
      rand_en = 1'b0;
   endtask

   task automatic test_clear;
      int cyc; bit seen; bit bf; int mc; int dones;
      clear_board(1'b0);
      bs_m[7][9] = 13'd100; ws_m[7][9] = 13'd50;
      run_scan(1'b0, cyc, seen, bf, mc);
      repeat (2) @(negedge clk);
      start = 1'b1;
      @(posedge clk); #1; start = 1'b0;
      repeat (99) @(posedge clk);
      @(negedge clk); clr = 1'b1;
      @(posedge clk); #1; clr = 1'b0;
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL clr_abort_busy got=%b want=0", busy); end
      dones = 0;
      for (int c = 0; c < 300; c++) begin
         @(posedge clk); #1;
         if (done === 1'b1) dones++;
      end
      total++; if (dones != 0) begin bad++; $display("FAIL clr_no_done got=%0d pulses want=0", dones); end
      total++; if (best_i !== 4'd7 || best_j !== 4'd9 || best_score !== 17'd250) begin bad++; $display("FAIL clr_hold got=(%0d,%0d,%0d) want=(7,9,250)", best_i, best_j, best_score); end
      run_scan(1'b0, cyc, seen, bf, mc);
      total++; if (!seen || cyc != 226) begin bad++; $display("FAIL clr_restart got=%0d want=226", cyc); end
      repeat (2) @(negedge clk);
      clr = 1'b1;
      @(posedge clk); #1; clr = 1'b0;
      total++; if (best_i !== 4'd7 || best_j !== 4'd7 || best_score !== 17'd0 || no_move !== 1'b0) begin bad++; $display("FAIL clr_idle got=(%0d,%0d,%0d,%b) want=(7,7,0,0)", best_i, best_j, best_score, no_move); end
      @(negedge clk); start = 1'b1; clr = 1'b1;
      @(posedge clk); #1; start = 1'b0; clr = 1'b0;
      repeat (3) @(posedge clk); #1;
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL clr_wins got busy=%b want=0", busy); end
   endtask

   task automatic test_size9;
      int cyc; bit seen; bit bf; int mc;
      clear_board(1'b0);
      bs_m[8][8] = 13'd100;
      side = 1'b0;
      run_scan(1'b1, cyc, seen, bf, mc);
      total++; if (!seen || cyc != 82) begin bad++; $display("FAIL n9_latency got=%0d want=82", cyc); end
      total++; if (best_i9 !== 4'd8 || best_j9 !== 4'd8 || best_score9 !== 17'd200) begin bad++; $display("FAIL n9_best got=(%0d,%0d,%0d) want=(8,8,200)", best_i9, best_j9, best_score9); end
      total++; if (mc > 8) begin bad++; $display("FAIL n9_addr_range got=%0d want<=8", mc); end
   endtask

   task automatic test_reset_mid_scan;
      int cyc; bit seen; bit bf; int mc; int dones;
      clear_board(1'b0);
      bs_m[7][9] = 13'd100;
      run_scan(1'b0, cyc, seen, bf, mc);
      repeat (2) @(negedge clk);
      start = 1'b1;
      @(posedge clk); #1; start = 1'b0;
      repeat (50) @(posedge clk);
      @(negedge clk); rst = 1'b0;
      #2;
      total++; if (busy !== 1'b0 || get_i !== 4'd0 || get_j !== 4'd0) begin bad++; $display("FAIL rst_mid_ctrl got busy=%b get=(%0d,%0d) want 0,(0,0)", busy, get_i, get_j); end
      total++; if (best_i !== 4'd7 || best_j !== 4'd7 || best_score !== 17'd0) begin bad++; $display("FAIL rst_mid_best got=(%0d,%0d,%0d) want=(7,7,0)", best_i, best_j, best_score); end
      @(negedge clk); rst = 1'b1;
      dones = 0;
      for (int c = 0; c < 300; c++) begin
         @(posedge clk); #1;
         if (done === 1'b1 || busy === 1'b1) dones++;
      end
      total++; if (dones != 0) begin bad++; $display("FAIL rst_mid_quiet got=%0d active cycles want=0", dones); end
   endtask

   initial begin
      clear_board(1'b0);
      test_reset();
      test_empty_board();
      test_single_peak();
      test_all_occupied();
      test_tie_break();
      test_clear();
      test_size9();
      test_reset_mid_scan();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
